// File: rtl/flag_gen_if.sv
// rtl/flag_gen_if.sv - op, control and flag signal bundle for flag_gen
interface flag_gen_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        shift_c;
    logic        stall;
    logic        flush;
    logic        msr_we;
    logic [3:0]  msr_data;
    logic        N;
    logic        Z;
    logic        C;
    logic        V;
    logic [3:0]  fwd_nzcv;
    logic        pend;

    modport master (
        output op_valid, op, a, b, res, shift_c, stall, flush, msr_we, msr_data,
        input  N, Z, C, V, fwd_nzcv, pend
    );

    modport slave (
        input  op_valid, op, a, b, res, shift_c, stall, flush, msr_we, msr_data,
        output N, Z, C, V, fwd_nzcv, pend
    );
endinterface

// File: rtl/flag_gen.sv
// rtl/flag_gen.sv - NZCV flag generation with one-stage pending/commit pipeline
module flag_gen (
    input  logic          clk,
    input  logic          rst_n,
    flag_gen_if.slave     bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_ADC   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_SBC   = 3'b011;
    localparam logic [2:0] OP_LOGIC = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;

    state_t      state, state_nx;
    logic [3:0]  pend_flags, pend_flags_nx;
    logic [3:0]  nzcv, nzcv_nx;
    logic [3:0]  fwd;
    logic [3:0]  new_flags;
    logic        op_known;
    logic        cin;
    logic [31:0] b_eff;
    logic [32:0] sum;

    // Forwarded view: in-flight flags win over committed ones, so chained ops see the latest result
    always_comb begin
        fwd = (state == PENDING) ? pend_flags : nzcv;
    end

    // Flag computation for the op presented this cycle; carry-in and held bits come from the forwarded view
    always_comb begin
        op_known  = 1'b1;
        cin       = 1'b0;
        b_eff     = bus.b;
        new_flags = fwd;
        case (bus.op)
            OP_ADD: begin cin = 1'b0;   b_eff = bus.b;  end
            OP_ADC: begin cin = fwd[1]; b_eff = bus.b;  end
            OP_SUB: begin cin = 1'b1;   b_eff = ~bus.b; end
            OP_SBC: begin cin = fwd[1]; b_eff = ~bus.b; end
            OP_LOGIC, OP_MUL: ;
            default: op_known = 1'b0;
        endcase
        sum = {1'b0, bus.a} + {1'b0, b_eff} + {32'd0, cin};
        case (bus.op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC:
                new_flags = {sum[31], (sum[31:0] == 32'd0), sum[32],
                             (bus.a[31] == b_eff[31]) & (sum[31] != bus.a[31])};
            OP_LOGIC:
                new_flags = {bus.res[31], (bus.res == 32'd0), bus.shift_c, fwd[0]};
            OP_MUL:
                new_flags = {bus.res[31], (bus.res == 32'd0), fwd[1], fwd[0]};
            default:
                new_flags = fwd;
        endcase
    end

    // Next-state: flush, then direct write, then stall, then commit/capture
    always_comb begin
        state_nx      = state;
        pend_flags_nx = pend_flags;
        nzcv_nx       = nzcv;
        if (bus.flush) begin
            state_nx      = IDLE;
            pend_flags_nx = 4'd0;
        end else if (bus.msr_we) begin
            state_nx      = IDLE;
            pend_flags_nx = 4'd0;
            nzcv_nx       = bus.msr_data;
        end else if (!bus.stall) begin
            if (state == PENDING) begin
                nzcv_nx  = pend_flags;
                state_nx = IDLE;
            end
            if (bus.op_valid && op_known) begin
                pend_flags_nx = new_flags;
                state_nx      = PENDING;
            end
        end
    end

    // State, pending and committed flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend_flags <= 4'd0;
            nzcv       <= 4'd0;
        end else begin
            state      <= state_nx;
            pend_flags <= pend_flags_nx;
            nzcv       <= nzcv_nx;
        end
    end

    assign bus.N        = nzcv[3];
    assign bus.Z        = nzcv[2];
    assign bus.C        = nzcv[1];
    assign bus.V        = nzcv[0];
    assign bus.fwd_nzcv = fwd;
    assign bus.pend     = (state == PENDING);
endmodule

// File: tb/tb_flag_gen.sv
// tb/tb_flag_gen.sv - directed self-checking bench for flag_gen
module tb_flag_gen;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    flag_gen_if bus ();

    flag_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.op_valid = 1'b0;
        bus.op       = 3'b000;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.res      = 32'd0;
        bus.shift_c  = 1'b0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.msr_we   = 1'b0;
        bus.msr_data = 4'd0;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic sc);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.res      = res;
        bus.shift_c  = sc;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] nzcv, input logic pend,
                             input logic [3:0] fwd);
        check({tag, "_nzcv"}, {28'd0, bus.N, bus.Z, bus.C, bus.V}, {28'd0, nzcv});
        check({tag, "_pend"}, {31'd0, bus.pend}, {31'd0, pend});
        check({tag, "_fwd"},  {28'd0, bus.fwd_nzcv}, {28'd0, fwd});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        rst_n = 1'b0;
        step();
        step();
        chk_state("reset", 4'b0000, 1'b0, 4'b0000);

        // SUB 5-5: pend after 1 cycle, commit after 2
        rst_n = 1'b1;
        set_op(3'b010, 32'd5, 32'd5, 32'd0, 1'b0);
        step();
        idle();
        chk_state("sub_cap", 4'b0000, 1'b1, 4'b0110);
        step();
        chk_state("sub_commit", 4'b0110, 1'b0, 4'b0110);

        // ADD overflow then back-to-back ADC chaining forwarded C
        set_op(3'b000, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0);
        step();
        chk_state("add_ovf", 4'b0110, 1'b1, 4'b1001);
        set_op(3'b001, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
        step();
        idle();
        chk_state("adc_chain", 4'b1001, 1'b1, 4'b1000);
        step();
        chk_state("adc_commit", 4'b1000, 1'b0, 4'b1000);

        // Stall holds pending for 3 cycles and ignores op_valid
        set_op(3'b000, 32'd1, 32'd1, 32'd0, 1'b0);
        step();
        set_op(3'b010, 32'd5, 32'd5, 32'd0, 1'b0);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state($sformatf("stall%0d", i), 4'b1000, 1'b1, 4'b0000);
        end
        idle();
        step();
        chk_state("stall_release", 4'b0000, 1'b0, 4'b0000);

        // Flush discards pending SUB 0-1
        set_op(3'b010, 32'd0, 32'd1, 32'd0, 1'b0);
        step();
        idle();
        chk_state("flush_cap", 4'b0000, 1'b1, 4'b1000);
        bus.flush = 1'b1;
        step();
        chk_state("flush", 4'b0000, 1'b0, 4'b0000);

        // Flush overrides stall and blocks a same-cycle op
        bus.stall = 1'b1;
        set_op(3'b010, 32'd0, 32'd1, 32'd0, 1'b0);
        step();
        idle();
        chk_state("flush_stall", 4'b0000, 1'b0, 4'b0000);

        // Direct write beats a same-cycle ADD
        set_op(3'b000, 32'd0, 32'd0, 32'd0, 1'b0);
        bus.msr_we   = 1'b1;
        bus.msr_data = 4'b1111;
        step();
        idle();
        chk_state("msr_op", 4'b1111, 1'b0, 4'b1111);

        // Direct write discards a pending update
        set_op(3'b010, 32'd5, 32'd5, 32'd0, 1'b0);
        step();
        idle();
        bus.msr_we   = 1'b1;
        bus.msr_data = 4'b0101;
        step();
        idle();
        chk_state("msr_pend", 4'b0101, 1'b0, 4'b0101);

        // Reserved op code changes nothing
        set_op(3'b110, 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        idle();
        chk_state("reserved", 4'b0101, 1'b0, 4'b0101);

        // LOGIC then MUL from NZCV=0010
        bus.msr_we   = 1'b1;
        bus.msr_data = 4'b0010;
        step();
        set_op(3'b100, 32'd0, 32'd0, 32'd0, 1'b0);
        bus.msr_we = 1'b0;
        step();
        chk_state("logic", 4'b0010, 1'b1, 4'b0100);
        set_op(3'b101, 32'd0, 32'd0, 32'h8000_0000, 1'b0);
        step();
        idle();
        chk_state("mul", 4'b0100, 1'b1, 4'b1000);
        step();
        chk_state("mul_commit", 4'b1000, 1'b0, 4'b1000);

        // LOGIC keeps V and takes shift carry
        bus.msr_we   = 1'b1;
        bus.msr_data = 4'b0001;
        step();
        set_op(3'b100, 32'd0, 32'd0, 32'd1, 1'b1);
        bus.msr_we = 1'b0;
        step();
        idle();
        chk_state("logic_v", 4'b0001, 1'b1, 4'b0011);

        // SBC with C=0: 5 + ~3 + 0
        bus.msr_we   = 1'b1;
        bus.msr_data = 4'b0000;
        step();
        set_op(3'b011, 32'd5, 32'd3, 32'd0, 1'b0);
        bus.msr_we = 1'b0;
        step();
        idle();
        chk_state("sbc", 4'b0000, 1'b1, 4'b0010);

        // Reset mid-operation, then capture on the first cycle out of reset
        set_op(3'b010, 32'd5, 32'd5, 32'd0, 1'b0);
        step();
        idle();
        rst_n = 1'b0;
        step();
        chk_state("reset_mid", 4'b0000, 1'b0, 4'b0000);
        rst_n = 1'b1;
        set_op(3'b000, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0);
        step();
        idle();
        chk_state("post_reset_cap", 4'b0000, 1'b1, 4'b1001);
        step();
        chk_state("post_reset_commit", 4'b1001, 1'b0, 4'b1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
